// File: rtl/multi_buffer_pkg.sv
// rtl/multi_buffer_pkg.sv - shared constants and helpers for the buffer rotation manager
package multi_buffer_pkg;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int BYTES           = DEF_DATA_WIDTH / 8;
  localparam int DEF_NUM_BUFFERS = 4;
  localparam int IDX_W           = $clog2(DEF_NUM_BUFFERS);

  function automatic logic [4:0] clamp_log_length(input logic [4:0] log_length,
                                                  input logic [4:0] max_log);
    return (log_length > max_log) ? max_log : log_length;
  endfunction
endpackage

// File: rtl/multi_buffer_manager_allocator.sv
// rtl/multi_buffer_manager_allocator.sv - picks the lowest buffer index not set in the exclusion mask
module buffer_allocator
  import multi_buffer_pkg::*;
#(
  parameter int NUM_BUFFERS = DEF_NUM_BUFFERS,
  parameter int IW          = $clog2(NUM_BUFFERS)
) (
  input  logic [NUM_BUFFERS-1:0] excl_mask,
  output logic [IW-1:0]          free_index
);
  always_comb begin
    free_index = '0;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      if (!excl_mask[i]) free_index = IW'(i);
    end
  end
endmodule

// File: rtl/multi_buffer_manager.sv
// rtl/multi_buffer_manager.sv - N-way reader/ready/writer buffer rotation with address generation
// Optional frame/drop statistics counters are enabled by MULTI_BUFFER_STATS_EN.
module multi_buffer_manager
  import multi_buffer_pkg::*;
#(
  parameter int MM_ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NUM_BUFFERS    = DEF_NUM_BUFFERS,
  parameter int MAX_LOG_LENGTH = 20
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [4:0]                   log_length,
  input  logic [MM_ADDR_WIDTH-1:0]     base_address,
  input  logic                         writing,
  input  logic                         request,
  output logic [MM_ADDR_WIDTH-1:0]     read_buffer,
  output logic [MM_ADDR_WIDTH-1:0]     write_buffer,
  output logic [$clog2(NUM_BUFFERS)-1:0] read_index,
  output logic [$clog2(NUM_BUFFERS)-1:0] write_index,
  output logic [$clog2(NUM_BUFFERS)-1:0] ready_index,
  output logic                         new_frame,
  output logic [NUM_BUFFERS-1:0]       busy_mask
`ifdef MULTI_BUFFER_STATS_EN
  ,
  output logic [31:0]                  frame_count,
  output logic [31:0]                  dropped_count
`endif
);
  localparam int IW         = $clog2(NUM_BUFFERS);
  localparam int WORD_BYTES = DATA_WIDTH / 8;
  localparam int CNT_W      = MAX_LOG_LENGTH + 1;
  localparam logic [4:0] MAX_LOG = 5'(MAX_LOG_LENGTH);

  logic [IW-1:0]          r_q, r_d, y_q, y_d, w_q, w_d, free_index;
  logic                   new_frame_q, new_frame_d, request_q, request_d;
  logic [CNT_W-1:0]       write_count_q, write_count_d, length_q, length_d, sampled_length;
  logic [NUM_BUFFERS-1:0] excl_mask;
  logic                   completion, req_edge;

  assign sampled_length = CNT_W'(1) << clamp_log_length(log_length, MAX_LOG);
  assign completion     = writing && (write_count_q == length_q - CNT_W'(1));
  assign req_edge       = request && !request_q;

  // A same-cycle completion is visible to the request, so the reader gets the fresh frame.
  always_comb begin
    y_d           = completion ? w_q : y_q;
    new_frame_d   = new_frame_q | completion;
    r_d           = r_q;
    if (req_edge && new_frame_d) begin
      r_d         = y_d;
      new_frame_d = 1'b0;
    end
    write_count_d = completion ? '0 : (writing ? write_count_q + CNT_W'(1) : write_count_q);
    length_d      = completion ? sampled_length : length_q;
    request_d     = request;
  end

  assign excl_mask = (NUM_BUFFERS'(1) << r_d) | (NUM_BUFFERS'(1) << y_d);

  buffer_allocator #(
    .NUM_BUFFERS (NUM_BUFFERS),
    .IW          (IW)
  ) u_allocator (
    .excl_mask  (excl_mask),
    .free_index (free_index)
  );

  always_comb begin
    w_d = completion ? free_index : w_q;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_q           <= '0;
      y_q           <= '0;
      w_q           <= IW'(1);
      new_frame_q   <= 1'b0;
      write_count_q <= '0;
      length_q      <= sampled_length;
      request_q     <= 1'b0;
    end else begin
      r_q           <= r_d;
      y_q           <= y_d;
      w_q           <= w_d;
      new_frame_q   <= new_frame_d;
      write_count_q <= write_count_d;
      length_q      <= length_d;
      request_q     <= request_d;
    end
  end

  assign read_buffer  = base_address
                      + MM_ADDR_WIDTH'(r_q) * MM_ADDR_WIDTH'(length_q) * MM_ADDR_WIDTH'(WORD_BYTES);
  assign write_buffer = base_address
                      + (MM_ADDR_WIDTH'(w_q) * MM_ADDR_WIDTH'(length_q) + MM_ADDR_WIDTH'(write_count_q))
                        * MM_ADDR_WIDTH'(WORD_BYTES);
  assign read_index   = r_q;
  assign write_index  = w_q;
  assign ready_index  = y_q;
  assign new_frame    = new_frame_q;
  assign busy_mask    = (NUM_BUFFERS'(1) << r_q) | (NUM_BUFFERS'(1) << y_q) | (NUM_BUFFERS'(1) << w_q);

`ifdef MULTI_BUFFER_STATS_EN
  logic [31:0] frame_count_q, frame_count_d, dropped_count_q, dropped_count_d;

  // An unconsumed frame replaced without a request edge in the same cycle is a drop.
  always_comb begin
    frame_count_d   = frame_count_q;
    dropped_count_d = dropped_count_q;
    if (completion && frame_count_q != 32'hFFFF_FFFF) frame_count_d = frame_count_q + 32'd1;
    if (completion && new_frame_q && !req_edge && dropped_count_q != 32'hFFFF_FFFF)
      dropped_count_d = dropped_count_q + 32'd1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      frame_count_q   <= '0;
      dropped_count_q <= '0;
    end else begin
      frame_count_q   <= frame_count_d;
      dropped_count_q <= dropped_count_d;
    end
  end

  assign frame_count   = frame_count_q;
  assign dropped_count = dropped_count_q;
`endif
endmodule

// File: tb/tb_multi_buffer_manager.sv
// tb/tb_multi_buffer_manager.sv - self-checking bench for multi_buffer_manager with a rule-level model
module tb_multi_buffer_manager;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [4:0]  log_length = 5'd2;
  logic [31:0] base_address = 32'h1000_0000;
  logic        writing = 1'b0;
  logic        request = 1'b0;
  logic [31:0] read_buffer, write_buffer;
  logic [1:0]  read_index, write_index, ready_index;
  logic        new_frame;
  logic [3:0]  busy_mask;
`ifdef MULTI_BUFFER_STATS_EN
  logic [31:0] frame_count, dropped_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int     m_r, m_y, m_w, m_wc;
  longint m_len;
  bit     m_nf, m_rqp;
  longint m_fc, m_dc;

  multi_buffer_manager dut (
    .aclk         (aclk),
    .areset       (areset),
    .log_length   (log_length),
    .base_address (base_address),
    .writing      (writing),
    .request      (request),
    .read_buffer  (read_buffer),
    .write_buffer (write_buffer),
    .read_index   (read_index),
    .write_index  (write_index),
    .ready_index  (ready_index),
    .new_frame    (new_frame),
    .busy_mask    (busy_mask)
`ifdef MULTI_BUFFER_STATS_EN
    ,
    .frame_count  (frame_count),
    .dropped_count(dropped_count)
`endif
  );

  always #5 aclk = ~aclk;

  function automatic longint clamped_len(input logic [4:0] ll);
    return longint'(1) << ((ll > 5'd20) ? 20 : int'(ll));
  endfunction

  function automatic logic [31:0] exp_wb();
    return 32'(longint'(base_address) + (longint'(m_w) * m_len + longint'(m_wc)) * 4);
  endfunction

  function automatic logic [31:0] exp_rb();
    return 32'(longint'(base_address) + longint'(m_r) * m_len * 4);
  endfunction

  function automatic logic [3:0] exp_busy();
    logic [3:0] b;
    b = '0;
    b[m_r] = 1'b1;
    b[m_y] = 1'b1;
    b[m_w] = 1'b1;
    return b;
  endfunction

  task automatic model_step(input bit rst, input bit wr, input bit rq);
    bit edge_seen, done;
    if (rst) begin
      m_r = 0; m_y = 0; m_w = 1; m_nf = 0; m_wc = 0;
      m_len = clamped_len(log_length); m_fc = 0; m_dc = 0; m_rqp = 0;
      return;
    end
    edge_seen = rq && !m_rqp;
    m_rqp = rq;
    done = wr && (m_wc + 1 == m_len);
    if (done) begin
      if (m_nf && !edge_seen) m_dc = (m_dc == 64'hFFFF_FFFF) ? m_dc : m_dc + 1;
      m_fc = (m_fc == 64'hFFFF_FFFF) ? m_fc : m_fc + 1;
      m_y = m_w; m_nf = 1; m_wc = 0;
      m_len = clamped_len(log_length);
    end else if (wr) begin
      m_wc++;
    end
    if (edge_seen && m_nf) begin
      m_r = m_y; m_nf = 0;
    end
    if (done) begin
      for (int i = 3; i >= 0; i--) if (i != m_r && i != m_y) m_w = i;
    end
  endtask

  task automatic cycle(input bit wr, input bit rq);
    writing = wr;
    request = rq;
    @(posedge aclk);
    model_step(areset, wr, rq);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    cycle(1'b0, 1'b0);
    areset = 1'b0;
  endtask

  task automatic test_reset();
    log_length = 5'd2;
    base_address = 32'h1000_0000;
    do_reset();
    n_checks++; if (read_buffer !== 32'h1000_0000) begin n_fail++; $display("FAIL reset_read_buffer got %h expected %h", read_buffer, 32'h1000_0000); end
    n_checks++; if (write_buffer !== 32'h1000_0010) begin n_fail++; $display("FAIL reset_write_buffer got %h expected %h", write_buffer, 32'h1000_0010); end
    n_checks++; if (new_frame !== 1'b0) begin n_fail++; $display("FAIL reset_new_frame got %b expected 0", new_frame); end
    n_checks++; if (read_index !== 2'd0 || write_index !== 2'd1) begin n_fail++; $display("FAIL reset_indices got r=%0d w=%0d expected r=0 w=1", read_index, write_index); end
  endtask

  task automatic test_rotation();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    n_checks++; if (ready_index !== 2'd1 || write_index !== 2'd2) begin n_fail++; $display("FAIL rot_roles got y=%0d w=%0d expected y=1 w=2", ready_index, write_index); end
    n_checks++; if (write_buffer !== 32'h1000_0020) begin n_fail++; $display("FAIL rot_write_buffer got %h expected %h", write_buffer, 32'h1000_0020); end
    n_checks++; if (new_frame !== 1'b1) begin n_fail++; $display("FAIL rot_new_frame got %b expected 1", new_frame); end
`ifdef MULTI_BUFFER_STATS_EN
    n_checks++; if (frame_count !== 32'd1) begin n_fail++; $display("FAIL rot_frame_count got %0d expected 1", frame_count); end
`endif
    cycle(1'b0, 1'b1);
    n_checks++; if (read_index !== 2'd1 || read_buffer !== 32'h1000_0010) begin n_fail++; $display("FAIL rot_request got r=%0d rb=%h expected r=1 rb=%h", read_index, read_buffer, 32'h1000_0010); end
    n_checks++; if (new_frame !== 1'b0) begin n_fail++; $display("FAIL rot_consume got %b expected 0", new_frame); end
    cycle(1'b0, 1'b0);
  endtask

  task automatic test_overwrite_and_same_cycle();
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
    n_checks++; if (ready_index !== 2'd2 || write_index !== 2'd1 || read_index !== 2'd0) begin n_fail++; $display("FAIL ovw_roles got r=%0d y=%0d w=%0d expected r=0 y=2 w=1", read_index, ready_index, write_index); end
`ifdef MULTI_BUFFER_STATS_EN
    n_checks++; if (dropped_count !== 32'd1) begin n_fail++; $display("FAIL ovw_dropped got %0d expected 1", dropped_count); end
`endif
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    n_checks++; if (read_index !== 2'd1 || new_frame !== 1'b0) begin n_fail++; $display("FAIL same_cycle got r=%0d nf=%b expected r=1 nf=0", read_index, new_frame); end
    n_checks++; if (write_index !== 2'(m_w) || busy_mask !== exp_busy()) begin n_fail++; $display("FAIL same_cycle_w got w=%0d busy=%b expected w=%0d busy=%b", write_index, busy_mask, m_w, exp_busy()); end
`ifdef MULTI_BUFFER_STATS_EN
    n_checks++; if (dropped_count !== 32'd1) begin n_fail++; $display("FAIL same_cycle_dropped got %0d expected 1", dropped_count); end
`endif
    cycle(1'b0, 1'b0);
  endtask

  task automatic test_held_request();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    n_checks++; if (read_index !== 2'd1) begin n_fail++; $display("FAIL held_edge got r=%0d expected 1", read_index); end
    for (int i = 0; i < 19; i++) cycle(i < 8, 1'b1);
    n_checks++; if (new_frame !== 1'b1 || read_index !== 2'd1) begin n_fail++; $display("FAIL held_level got nf=%b r=%0d expected nf=1 r=1", new_frame, read_index); end
    n_checks++; if (ready_index !== 2'(m_y) || write_index !== 2'(m_w)) begin n_fail++; $display("FAIL held_roles got y=%0d w=%0d expected y=%0d w=%0d", ready_index, write_index, m_y, m_w); end
    cycle(1'b0, 1'b0);
  endtask

  task automatic test_length_change();
    log_length = 5'd2;
    do_reset();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    log_length = 5'd3;
    n_checks++; if (write_buffer !== 32'h1000_0018) begin n_fail++; $display("FAIL len_mid got %h expected %h", write_buffer, 32'h1000_0018); end
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    n_checks++; if (write_buffer !== 32'h1000_0040 || read_buffer !== 32'h1000_0000) begin n_fail++; $display("FAIL len_after got wb=%h rb=%h expected wb=%h rb=%h", write_buffer, read_buffer, 32'h1000_0040, 32'h1000_0000); end
    cycle(1'b0, 1'b1);
    n_checks++; if (read_buffer !== 32'h1000_0020) begin n_fail++; $display("FAIL len_read got %h expected %h", read_buffer, 32'h1000_0020); end
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    log_length = 5'd2;
    areset = 1'b1;
    cycle(1'b1, 1'b0);
    areset = 1'b0;
    n_checks++; if (write_buffer !== 32'h1000_0010 || read_buffer !== 32'h1000_0000 || new_frame !== 1'b0 || busy_mask !== 4'b0011) begin n_fail++; $display("FAIL mid_reset got wb=%h rb=%h nf=%b busy=%b expected wb=%h rb=%h nf=0 busy=0011", write_buffer, read_buffer, new_frame, busy_mask, 32'h1000_0010, 32'h1000_0000); end
  endtask

  task automatic test_clamp();
    log_length = 5'd31;
    do_reset();
    n_checks++; if (write_buffer !== 32'h1040_0000) begin n_fail++; $display("FAIL clamp got %h expected %h", write_buffer, 32'h1040_0000); end
    cycle(1'b1, 1'b0);
    n_checks++; if (write_buffer !== 32'h1040_0004) begin n_fail++; $display("FAIL clamp_step got %h expected %h", write_buffer, 32'h1040_0004); end
  endtask

  task automatic test_random();
    base_address = $urandom;
    log_length = 5'($urandom_range(0, 2));
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) log_length = 5'($urandom_range(0, 3));
      areset = ($urandom_range(0, 149) == 0);
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0);
      areset = 1'b0;
      n_checks++; if (read_index !== 2'(m_r) || ready_index !== 2'(m_y) || write_index !== 2'(m_w)) begin n_fail++; $display("FAIL rnd_roles cyc %0d got r=%0d y=%0d w=%0d expected r=%0d y=%0d w=%0d", n, read_index, ready_index, write_index, m_r, m_y, m_w); end
      n_checks++; if (new_frame !== m_nf) begin n_fail++; $display("FAIL rnd_new_frame cyc %0d got %b expected %b", n, new_frame, m_nf); end
      n_checks++; if (write_buffer !== exp_wb() || read_buffer !== exp_rb()) begin n_fail++; $display("FAIL rnd_addr cyc %0d got wb=%h rb=%h expected wb=%h rb=%h", n, write_buffer, read_buffer, exp_wb(), exp_rb()); end
      n_checks++; if (busy_mask !== exp_busy()) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %b expected %b", n, busy_mask, exp_busy()); end
`ifdef MULTI_BUFFER_STATS_EN
      n_checks++; if (frame_count !== 32'(m_fc) || dropped_count !== 32'(m_dc)) begin n_fail++; $display("FAIL rnd_stats cyc %0d got f=%0d d=%0d expected f=%0d d=%0d", n, frame_count, dropped_count, m_fc, m_dc); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_overwrite_and_same_cycle();
    test_held_request();
    test_length_change();
    test_clamp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
